scan_decoder: RTL and testbench
===============================

Name: scan_decoder

Overview:
- Parametrised, registered successor to the 4-to-16 decoder. Drives an N-to-2^N one-hot output with enable.
- Adds two things the plain decoder lacks:
  - a registered direct-decode mode;
  - a self-timed scan mode that walks the one-hot output through all 2^N positions, up or down, with a programmable dwell per position.
- Used for display/keypad column scanning and for sequenced select-line generation.

Parameters:
- N, 4, select width; output width is 2^N.
- DWELL, 1, clock cycles each one-hot position is held during scan (range 1..65535).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; low freezes the FSM and blanks dout.
- mode  input  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 reserved (treated as DIRECT).
- in  input  N  decode select (DIRECT) or start index (scan).
- start  input  1  single-cycle request to begin a scan; sampled only in IDLE.
- dout  output  2^N  registered one-hot output; all-zero when inactive.
- idx  output  N  index currently driven on dout.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when a scan completes.

Behaviour:
- Reset (rst_n low, asynchronous): dout=0, idx=0, busy=0, done=0, state=IDLE, dwell counter=0, position counter=0. Release is synchronous to the next clk edge.
- FSM states: IDLE, SCAN. All outputs are registered.
- IDLE, en=1, start=0, mode DIRECT/11:
  - dout <= 1<<in; idx <= in.
  - Latency is 1 clock: a change on in appears on dout at the next edge.
- IDLE, en=1, start=0, mode SCAN_UP/DOWN: dout <= 0, idx holds.
- IDLE, en=1, start=1, mode SCAN_UP/DOWN:
  - Latch the direction.
  - idx <= in; dout <= 1<<in.
  - busy <= 1; dwell counter <= 0; position counter <= 0.
  - Go to SCAN.
- IDLE, start=1 with mode DIRECT/11: start is ignored; direct decode proceeds.
- SCAN, en=1:
  - Dwell counter increments every cycle.
  - When it reaches DWELL-1 it clears, position counter increments, and idx steps +1 (up) or -1 (down) modulo 2^N.
  - Wrap: idx 2^N-1 -> 0 (up) and 0 -> 2^N-1 (down).
  - dout always equals 1<<idx.
- Scan completion:
  - The scan shows exactly 2^N positions, each for DWELL cycles, i.e. 2^N*DWELL cycles total, beginning at the edge that accepted start.
  - At the end of the last dwell: state <= IDLE, busy <= 0, done <= 1 for one cycle, dout <= 0, idx holds the last index.
- Inputs ignored in SCAN: start, mode and in changes are ignored; direction stays latched.
- en=0, any state:
  - dout <= 0 at the next edge.
  - FSM, idx, dwell counter and position counter freeze; busy holds; done <= 0.
- en returning to 1 in SCAN: dout <= 1<<idx at the next edge; the dwell count resumes where it left off. The frozen cycles do not count toward the dwell.
- done: never asserted in the same cycle as busy.
- Back-to-back scans: the next start is accepted in the cycle after done (the FSM is already in IDLE).
- Reset mid-scan: immediate return to the reset values. No done pulse.
- Invariant: dout is always either zero or one-hot. It is never multi-hot, including on the cycle of the SCAN -> IDLE transition.

Test Plan:
- N=4, DIRECT, en=1, sweep in 0..15 -> dout=16'h0001..16'h8000 one cycle after each in change; idx tracks in; busy=0.
- DIRECT with en=0, in=5 -> dout=0 next edge. Raise en -> dout=16'h0020 next edge.
- N=4, DWELL=1, SCAN_UP, in=14, start pulse:
  - idx sequence 14,15,0,1,…,13, one per cycle (16 cycles);
  - busy high throughout;
  - then done=1 for one cycle, dout=0, busy=0.
- N=4, DWELL=3, SCAN_DOWN, in=1:
  - idx 1,0,15,…,2, each held 3 cycles;
  - done pulse 48 cycles after start was accepted.
- DWELL=3 scan with en dropped for 5 cycles mid-dwell -> dout=0 during the gap; the position does not advance; total time to done = 48+5 cycles. A start pulse mid-scan is ignored.
- Assert rst_n low mid-scan -> dout, idx, busy and done go to 0 asynchronously with no done pulse. A new start after release begins a fresh scan.

Source files
------------

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a direct mode and a self-timed
// up/down scan mode that holds each position for DWELL cycles.
module scan_decoder #(
    parameter int N     = 4,
    parameter int DWELL = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [N-1:0]         in,
    input  logic                 start,
    output logic [(1<<N)-1:0]    dout,
    output logic [N-1:0]         idx,
    output logic                 busy,
    output logic                 done
);
    localparam int          W       = 1 << N;
    localparam logic [15:0] DW_LAST = 16'(DWELL - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t         state, state_n;
    logic [15:0]    dwell, dwell_n;
    logic [N-1:0]   pos, pos_n;
    logic           dir, dir_n;          // 1 = counting down
    logic [W-1:0]   dout_n;
    logic [N-1:0]   idx_n, idx_step;
    logic           busy_n, done_n;
    logic           is_scan;

    function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    assign is_scan  = (mode == 2'b01) || (mode == 2'b10);
    assign idx_step = dir ? idx - N'(1) : idx + N'(1);

    always_comb begin
        state_n = state;
        dwell_n = dwell;
        pos_n   = pos;
        dir_n   = dir;
        dout_n  = dout;
        idx_n   = idx;
        busy_n  = busy;
        done_n  = 1'b0;
        if (!en) begin
            // Everything freezes; only the output is blanked.
            dout_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_scan && start) begin
                        dir_n   = (mode == 2'b10);
                        idx_n   = in;
                        dout_n  = onehot(in);
                        busy_n  = 1'b1;
                        dwell_n = '0;
                        pos_n   = '0;
                        state_n = SCAN;
                    end else if (is_scan) begin
                        dout_n = '0;
                    end else begin
                        idx_n  = in;
                        dout_n = onehot(in);
                    end
                end
                SCAN: begin
                    if (dwell == DW_LAST) begin
                        dwell_n = '0;
                        if (pos == {N{1'b1}}) begin
                            // Last position finished: blank, leave idx on the final index.
                            state_n = IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            dout_n  = '0;
                        end else begin
                            pos_n  = pos + N'(1);
                            idx_n  = idx_step;
                            dout_n = onehot(idx_step);
                        end
                    end else begin
                        dwell_n = dwell + 16'd1;
                        dout_n  = onehot(idx);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dwell <= '0;
            pos   <= '0;
            dir   <= 1'b0;
            dout  <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            dwell <= dwell_n;
            pos   <= pos_n;
            dir   <= dir_n;
            dout  <= dout_n;
            idx   <= idx_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end
endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench: one instance with DWELL=1 (direct + fast scan), one with
// DWELL=3 (slow down-scan, enable gap, mid-scan reset).
module tb_scan_decoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en1, start1, en3, start3;
    logic [1:0]  mode1, mode3;
    logic [3:0]  in1, in3;
    logic [15:0] dout1, dout3;
    logic [3:0]  idx1, idx3;
    logic        busy1, done1, busy3, done3;
    int          tests = 0;
    int          fails = 0;

    scan_decoder #(.N(4), .DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .in(in1), .start(start1),
        .dout(dout1), .idx(idx1), .busy(busy1), .done(done1));

    scan_decoder #(.N(4), .DWELL(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .in(in3), .start(start3),
        .dout(dout3), .idx(idx3), .busy(busy3), .done(done3));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        en1 = 1'b0; mode1 = 2'b00; in1 = '0; start1 = 1'b0;
        en3 = 1'b0; mode3 = 2'b00; in3 = '0; start3 = 1'b0;
        #2;
        chk("rst_dout", 32'(dout1), 0);
        chk("rst_idx",  32'(idx1),  0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(done3), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Direct decode sweep
        en1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in1 = 4'(i);
            tick();
            chk("dir_dout", 32'(dout1), 32'(1) << i);
            chk("dir_idx",  32'(idx1),  32'(i));
            chk("dir_busy", 32'(busy1), 0);
        end
        mode1 = 2'b11; in1 = 4'd3;
        tick();
        chk("rsv_dout", 32'(dout1), 32'h0008);
        mode1 = 2'b00; in1 = 4'd7; start1 = 1'b1;
        tick();
        chk("dir_start_dout", 32'(dout1), 32'h0080);
        chk("dir_start_busy", 32'(busy1), 0);
        start1 = 1'b0; en1 = 1'b0; in1 = 4'd5;
        tick();
        chk("en0_dout", 32'(dout1), 0);
        en1 = 1'b1;
        tick();
        chk("en1_dout", 32'(dout1), 32'h0020);
        mode1 = 2'b01;
        tick();
        chk("scanidle_dout", 32'(dout1), 0);
        chk("scanidle_idx",  32'(idx1),  5);

        // Scan up, DWELL=1, from 14
        in1 = 4'd14; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("up_idx",  32'(idx1),  32'((14 + k) % 16));
            chk("up_dout", 32'(dout1), 32'(1) << ((14 + k) % 16));
            chk("up_busy", 32'(busy1), 1);
            chk("up_done", 32'(done1), 0);
            tick();
        end
        chk("up_end_done", 32'(done1), 1);
        chk("up_end_busy", 32'(busy1), 0);
        chk("up_end_dout", 32'(dout1), 0);
        chk("up_end_idx",  32'(idx1),  13);
        // Back-to-back start in the cycle after done
        in1 = 4'd0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("b2b_idx",  32'(idx1),  0);
        chk("b2b_busy", 32'(busy1), 1);
        chk("b2b_done", 32'(done1), 0);

        // Scan down, DWELL=3, from 1
        en3 = 1'b1; mode3 = 2'b10; in3 = 4'd1; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 0; k < 48; k++) begin
            chk("dn_idx",  32'(idx3),  32'((1 - k / 3 + 16) % 16));
            chk("dn_dout", 32'(dout3), 32'(1) << ((1 - k / 3 + 16) % 16));
            chk("dn_busy", 32'(busy3), 1);
            chk("dn_done", 32'(done3), 0);
            tick();
        end
        chk("dn_end_done", 32'(done3), 1);
        chk("dn_end_busy", 32'(busy3), 0);
        chk("dn_end_dout", 32'(dout3), 0);
        chk("dn_end_idx",  32'(idx3),  2);

        // Scan up from 4 with a 5-cycle enable gap mid-dwell and an ignored start
        mode3 = 2'b01; in3 = 4'd4; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        tick();
        en3 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("gap_dout", 32'(dout3), 0);
            chk("gap_idx",  32'(idx3),  4);
            chk("gap_busy", 32'(busy3), 1);
        end
        en3 = 1'b1;
        tick();
        chk("resume_dout", 32'(dout3), 32'h0010);
        start3 = 1'b1; mode3 = 2'b00; in3 = 4'd9;
        tick();
        start3 = 1'b0;
        chk("ign_idx",  32'(idx3),  5);
        chk("ign_busy", 32'(busy3), 1);
        cnt = 8;
        while (!done3 && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("gap_total", 32'(cnt), 53);
        chk("gap_end_idx", 32'(idx3), 3);

        // Reset in the middle of a scan
        mode3 = 2'b01; in3 = 4'd0; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dout", 32'(dout3), 0);
        chk("arst_idx",  32'(idx3),  0);
        chk("arst_busy", 32'(busy3), 0);
        chk("arst_done", 32'(done3), 0);
        tick();
        chk("arst_hold_done", 32'(done3), 0);
        rst_n = 1'b1; in3 = 4'd7; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("fresh_idx",  32'(idx3),  7);
        chk("fresh_dout", 32'(dout3), 32'h0080);
        chk("fresh_busy", 32'(busy3), 1);
        repeat (3) tick();
        chk("fresh_step", 32'(idx3), 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
